// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, constants and helpers for the sipo_deser deserializer
package sipo_pkg;

  typedef enum logic {
    ORDER_MSB = 1'b0,
    ORDER_LSB = 1'b1
  } bit_order_e;

  // XOR over data bits plus parity bit that a good frame must produce
  localparam logic PARITY_EVEN = 1'b0;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// rtl/sipo_out_slot.sv - single-entry valid/ready holding register with sticky overrun flag
module sipo_out_slot
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             word_perr,
  input  logic             push,
  input  logic             q_ready,
  input  logic             clear_ovr,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
  output logic             overrun,
  output logic             parity_err
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;
  logic             slot_free;

  always_comb begin
    slot_free = !valid_q || q_ready;
    word_d    = word_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ovr_d     = ovr_q && !clear_ovr;
    // A drop on the same edge as clear_ovr must still be reported, so set wins
    if (push) begin
      if (slot_free) begin
        word_d  = word;
        valid_d = 1'b1;
        perr_d  = word_perr;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && q_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign Q          = word_q;
  assign q_valid    = valid_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in/parallel-out deserializer; SIPO_DESER_PARITY_EN adds a trailing even-parity bit per frame
module sipo_deser
  import sipo_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Din,
  input  logic             din_valid,
  input  logic             msb_first,
  input  logic             clear_ovr,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             parity_err
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME_LAST = WIDTH;
`else
  localparam int FRAME_LAST = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LAST);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bit_order_e       order_q, order_d;
  bit_order_e       cur_order;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;
  logic             word_perr;
  logic             push;

  always_comb begin
    // The first bit of a word uses the live msb_first; later bits use the latched order
    if (cnt_q == '0) begin
      cur_order = msb_first ? ORDER_MSB : ORDER_LSB;
    end else begin
      cur_order = order_q;
    end
    if (cur_order == ORDER_MSB) begin
      sr_shift = {sr_q[WIDTH-2:0], Din};
    end else begin
      sr_shift = {Din, sr_q[WIDTH-1:1]};
    end

    sr_d    = sr_q;
    cnt_d   = cnt_q;
    order_d = order_q;
    push    = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    word      = sr_q;
    word_perr = ((^sr_q) ^ Din) != PARITY_EVEN;
`else
    word      = sr_shift;
    word_perr = 1'b0;
`endif

    if (din_valid) begin
      order_d = cur_order;
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`ifdef SIPO_DESER_PARITY_EN
      if (cnt_q != LAST_CNT) begin
        sr_d = sr_shift;
      end
`else
      sr_d = sr_shift;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      order_q <= ORDER_MSB;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
    end
  end

  assign bit_cnt = cnt_q;

  sipo_out_slot #(
    .WIDTH(WIDTH)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .word      (word),
    .word_perr (word_perr),
    .push      (push),
    .q_ready   (q_ready),
    .clear_ovr (clear_ovr),
    .Q         (Q),
    .q_valid   (q_valid),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Parametrised serial-in/parallel-out deserializer. It is the successor to the fixed 4-bit SIPO register and adds:
- configurable word width
- a per-bit valid qualifier
- a selectable MSB-first or LSB-first bit order
- a bit counter that delimits words
- a valid/ready output slot with overrun detection

It sits between a serial bit source (line receiver, bit-banged interface) and word-oriented downstream logic.

Parameters:
WIDTH, 8, parallel word width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
Din  input  1  serial data bit.
din_valid  input  1  Din is sampled this cycle when high.
msb_first  input  1  1 = first received bit lands in Q[WIDTH-1]; 0 = first bit lands in Q[0].
clear_ovr  input  1  synchronous clear of the overrun flag.
Q  output  WIDTH  assembled parallel word (registered).
q_valid  output  1  Q holds an unconsumed word.
q_ready  input  1  downstream accepts Q this cycle when q_valid is high.
overrun  output  1  sticky: a completed word was dropped.
bit_cnt  output  CNT_W  bits received so far in the current word.
parity_err  output  1  parity result for Q; constant 0 unless PARITY_EN.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst high at an edge) clears: shift reg, bit_cnt, Q, q_valid, overrun, parity_err, and the latched mode.
  - rst overrides every other input.
  - Reset mid-word discards the partial word.
- Bit accept: only on edges with din_valid=1. With din_valid=0, shift reg and bit_cnt hold, so gaps between bits are legal.
- Mode latch: msb_first is captured on the accepted bit where bit_cnt==0. It is held for the rest of the word. Changes mid-word take effect from the next word.
- Shift direction:
  - MSB-first: sr <= {sr[WIDTH-2:0], Din}.
  - LSB-first: sr <= {Din, sr[WIDTH-1:1]}.
- Counting: bit_cnt increments per accepted bit. On the final accepted bit of a word (bit_cnt==WIDTH-1, or WIDTH with PARITY_EN), bit_cnt wraps to 0.
- Word complete: the word is the shifted value including the final bit.
- Slot free condition: q_valid==0, or q_ready==1 in the same cycle.
  - Slot free: Q <= word, q_valid <= 1.
  - Latency: Q is valid on the edge that samples the last bit. It is observable the cycle after that edge.
- Handoff: q_valid && q_ready with no word completing clears q_valid on that edge. Q retains its old value.
- Simultaneous handoff and completion: Q loads the new word and q_valid stays 1, with no bubble.
- Overrun: a word completes while q_valid=1 and q_ready=0.
  - The new word is dropped; Q and q_valid are unchanged; overrun <= 1.
  - The counter still wraps, so the next word starts aligned.
- overrun is sticky until clear_ovr or rst. If clear_ovr and a new overrun occur on the same edge, overrun stays 1 (set wins).
- Back-to-back words with q_ready tied high: one Q update per WIDTH accepted bits, with no lost bits.

Optional Feature:
Macro SIPO_DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits plus one trailing even-parity bit.
  - The parity bit is not shifted into sr.
  - parity_err = XOR(word bits, parity bit) is registered together with Q and follows the same slot/overrun rules.
  - bit_cnt counts 0..WIDTH.
  - The word is delivered even when parity fails.
- Undefined: frames are WIDTH bits and parity_err is tied 0.

Decomposition:
- Package sipo_pkg:
  - function for counter width
  - enum for bit order (ORDER_MSB, ORDER_LSB)
  - localparam for parity polarity (EVEN)
- One natural sub-module, sipo_out_slot:
  - single-entry valid/ready holding register
  - inputs: word, push, q_ready, clear_ovr
  - outputs: Q, q_valid, overrun, parity_err
  - owns the handoff, overrun and set-wins logic
- The top holds the shift register, mode latch and counter.

Test Plan:
- WIDTH=4, msb_first=1, q_ready=1, bits 1,0,1,1 on consecutive edges -> Q=4'b1011 with q_valid high for exactly one cycle after the 4th edge; bit_cnt back to 0.
- Same bits with msb_first=0 -> Q=4'b1101. Toggling msb_first after bit 2 -> no effect on the current word.
- din_valid gaps: bits 0,1,1,0 with 3 idle cycles between each -> Q=4'b0110; bit_cnt holds during idle cycles.
- q_ready=0, send 0110 then 1001 -> Q stays 0110, overrun=1 after the 8th bit. Pulse clear_ovr -> overrun=0. Raise q_ready -> q_valid drops.
- rst after 2 bits (1,1), then send 0,0,1,1 -> Q=4'b0011. After rst: Q=0, q_valid=0, overrun=0.
- SIPO_DESER_PARITY_EN, bits 1,0,1,1 + parity 1 -> Q=1011, parity_err=0. Same data with parity 0 -> parity_err=1.
